// File: rtl/decode_exec_stage.sv
// Decodes a raw 32-bit instruction into exec-unit control and queues it with its PC in a small output FIFO.
// Latency: an accepted instruction is at the head one cycle later when the FIFO was empty. Outputs come from the head entry.
// Backpressure: in_ready is a registered !full. The head is held stable while out_valid && !out_ready. flush drops all entries.
module decode_exec_stage #(
    parameter int XLEN  = 32,
    parameter int M_EXT = 1,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_exec_op,
    output logic [1:0]      out_op1_sel,
    output logic            out_op2_sel,
    output logic            out_is_word,
    output logic            out_is_muldiv,
    output logic            out_illegal,
    output logic [XLEN-1:0] out_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

    localparam logic [1:0] SEL1_REG  = 2'd0;
    localparam logic [1:0] SEL1_PC   = 2'd1;
    localparam logic [1:0] SEL1_ZERO = 2'd2;

    typedef struct packed {
        logic [3:0]      exec_op;
        logic [1:0]      op1_sel;
        logic            op2_sel;
        logic            is_word;
        logic            is_muldiv;
        logic            illegal;
        logic [XLEN-1:0] pc;
    } entry_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    // Register indices and immediates are not needed for exec control.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{in_instr[24:15], in_instr[11:7]};

    logic [3:0] d_op;
    logic [1:0] d_op1;
    logic       d_op2;
    logic       d_word;
    logic       d_md;
    logic       d_bad;
    logic       shift_f3;
    entry_t     new_entry;

    // Instruction decode; any illegal outcome collapses all control fields to zero.
    always_comb begin
        d_op     = 4'b0000;
        d_op1    = SEL1_REG;
        d_op2    = 1'b0;
        d_word   = 1'b0;
        d_md     = 1'b0;
        d_bad    = 1'b0;
        shift_f3 = (f3 == 3'b001) || (f3 == 3'b101);
        if (in_instr[1:0] != 2'b11) begin
            d_bad = 1'b1;
        end else begin
            case (opc)
                OPC_OP, OPC_OP_32: begin
                    d_word = (opc == OPC_OP_32);
                    if (d_word && (XLEN != 64)) d_bad = 1'b1;
                    case (f7)
                        7'b0000000: begin
                            d_op = {1'b0, f3};
                            if (d_word && !(f3 == 3'b000 || shift_f3)) d_bad = 1'b1;
                        end
                        7'b0100000: begin
                            d_op = {1'b1, f3};
                            if (!(f3 == 3'b000 || f3 == 3'b101)) d_bad = 1'b1;
                        end
                        7'b0000001: begin
                            d_md = 1'b1;
                            d_op = {1'b0, f3};
                            if (M_EXT == 0) d_bad = 1'b1;
                            if (d_word && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011)) d_bad = 1'b1;
                        end
                        default: d_bad = 1'b1;
                    endcase
                end
                OPC_OP_IMM, OPC_OP_IMM_32: begin
                    d_word = (opc == OPC_OP_IMM_32);
                    d_op2  = 1'b1;
                    d_op   = {(f3 == 3'b101) & f7[5], f3};
                    if (d_word && (XLEN != 64)) d_bad = 1'b1;
                    if (d_word && !(f3 == 3'b000 || shift_f3)) d_bad = 1'b1;
                    if (f3 == 3'b001 && f7[6:1] != 6'b000000) d_bad = 1'b1;
                    if (f3 == 3'b101 && !(f7[6:1] == 6'b000000 || f7[6:1] == 6'b010000)) d_bad = 1'b1;
                    // Shamt bit 5 only exists for full-width RV64 shifts.
                    if (shift_f3 && f7[0] && (d_word || (XLEN != 64))) d_bad = 1'b1;
                end
                OPC_BRANCH, OPC_JAL, OPC_AUIPC: begin
                    d_op1 = SEL1_PC;
                    d_op2 = 1'b1;
                end
                OPC_LUI: begin
                    d_op1 = SEL1_ZERO;
                    d_op2 = 1'b1;
                end
                OPC_JALR, OPC_LOAD, OPC_STORE, OPC_SYSTEM, OPC_MISC_MEM: begin
                    d_op2 = 1'b1;
                end
                default: d_bad = 1'b1;
            endcase
        end
        new_entry         = '0;
        new_entry.pc      = in_pc;
        new_entry.illegal = d_bad;
        if (!d_bad) begin
            new_entry.exec_op   = d_op;
            new_entry.op1_sel   = d_op1;
            new_entry.op2_sel   = d_op2;
            new_entry.is_word   = d_word;
            new_entry.is_muldiv = d_md;
        end
    end

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_next;
    logic            in_ready_q;
    logic            push;
    logic            pop;

    assign out_valid  = (count != '0);
    assign in_ready   = in_ready_q;
    assign push       = in_valid && in_ready_q && !flush;
    assign pop        = out_valid && out_ready;
    assign count_next = count + CW'(push) - CW'(pop);

    // FIFO state; in_ready is registered from the count the next cycle will see.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (push) begin
                mem[wr_ptr] <= new_entry;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count      <= count_next;
            in_ready_q <= (count_next != CW'(DEPTH));
        end
    end

    assign out_exec_op   = mem[rd_ptr].exec_op;
    assign out_op1_sel   = mem[rd_ptr].op1_sel;
    assign out_op2_sel   = mem[rd_ptr].op2_sel;
    assign out_is_word   = mem[rd_ptr].is_word;
    assign out_is_muldiv = mem[rd_ptr].is_muldiv;
    assign out_illegal   = mem[rd_ptr].illegal;
    assign out_pc        = mem[rd_ptr].pc;

endmodule

// File: tb/tb_decode_exec_stage.sv
// Bench for decode_exec_stage (XLEN=64, M_EXT=1, DEPTH=2): directed cases plus random traffic.
// Expected entries come from a rule-level decode model and sit in a queue until the DUT presents them.
// A negedge monitor checks valid/ready against the queue occupancy and compares the head against the queue front.
module tb_decode_exec_stage;

    localparam int TB_XLEN  = 64;
    localparam int TB_M     = 1;
    localparam int TB_DEPTH = 2;

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  op1;
        logic        op2;
        logic        word;
        logic        md;
        logic        ill;
        logic [63:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [63:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_exec_op;
    logic [1:0]  out_op1_sel;
    logic        out_op2_sel;
    logic        out_is_word;
    logic        out_is_muldiv;
    logic        out_illegal;
    logic [63:0] out_pc;

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;
    exp_t q[$];

    decode_exec_stage #(.XLEN(TB_XLEN), .M_EXT(TB_M), .DEPTH(TB_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_exec_op(out_exec_op), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
        .out_is_word(out_is_word), .out_is_muldiv(out_is_muldiv), .out_illegal(out_illegal),
        .out_pc(out_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the instruction-class rules.
    function automatic exp_t model(input logic [31:0] i, input logic [63:0] pc);
        exp_t e;
        bit   ill;
        bit   w;
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
        e = '0; ill = 0; w = 0;
        if (i[1:0] != 2'b11) ill = 1;
        else if (opc == 7'h33 || opc == 7'h3B) begin
            w = (opc == 7'h3B);
            e.word = w;
            if (w && TB_XLEN == 32) ill = 1;
            if (f7 == 7'h00) begin
                e.op = {1'b0, f3};
                if (w && !(f3 inside {3'd0, 3'd1, 3'd5})) ill = 1;
            end else if (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})) begin
                e.op = {1'b1, f3};
            end else if (f7 == 7'h01) begin
                e.md = 1; e.op = {1'b0, f3};
                if (TB_M == 0) ill = 1;
                if (w && !(f3 inside {3'd0, 3'd4, 3'd5, 3'd6, 3'd7})) ill = 1;
            end else ill = 1;
        end else if (opc == 7'h13 || opc == 7'h1B) begin
            w = (opc == 7'h1B);
            e.word = w; e.op2 = 1;
            e.op = {(f3 == 3'd5) && f7[5], f3};
            if (w && TB_XLEN == 32) ill = 1;
            if (w && !(f3 inside {3'd0, 3'd1, 3'd5})) ill = 1;
            if (f3 == 3'd1 && f7[6:1] != 0) ill = 1;
            if (f3 == 3'd5 && !(f7[6:1] == 6'd0 || f7[6:1] == 6'h10)) ill = 1;
            if ((f3 inside {3'd1, 3'd5}) && f7[0] && (w || TB_XLEN == 32)) ill = 1;
        end else if (opc inside {7'h63, 7'h6F, 7'h17}) begin
            e.op1 = 2'd1; e.op2 = 1;
        end else if (opc == 7'h37) begin
            e.op1 = 2'd2; e.op2 = 1;
        end else if (opc inside {7'h67, 7'h03, 7'h23, 7'h73, 7'h0F}) begin
            e.op2 = 1;
        end else ill = 1;
        if (ill) begin
            e = '0;
            e.ill = 1;
        end
        e.pc = pc;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0] opc;
        logic [6:0] f7;
        case ($urandom_range(0, 15))
            0: opc = 7'h33;  1: opc = 7'h33;  2: opc = 7'h13;  3: opc = 7'h13;
            4: opc = 7'h3B;  5: opc = 7'h1B;  6: opc = 7'h63;  7: opc = 7'h6F;
            8: opc = 7'h17;  9: opc = 7'h37; 10: opc = 7'h67; 11: opc = 7'h03;
           12: opc = 7'h23; 13: opc = 7'h73; 14: opc = 7'h0F;
           default: opc = 7'($urandom);
        endcase
        case ($urandom_range(0, 4))
            0: f7 = 7'h00;  1: f7 = 7'h20;  2: f7 = 7'h01;  3: f7 = 7'h21;
            default: f7 = 7'($urandom);
        endcase
        return {f7, 10'($urandom), 3'($urandom), 5'($urandom), opc};
    endfunction

    // One cycle of stimulus; the expected entry is queued only if the DUT accepted it and no flush hit.
    task automatic step(input bit v, input logic [31:0] ins, input logic [63:0] pc,
                        input bit ordy, input bit fl);
        bit   acc;
        bit   flv;
        exp_t e;
        in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        e = model(ins, pc);
        @(negedge clk);
        acc = in_valid && in_ready;
        flv = flush;
        @(posedge clk);
        if (flv) q.delete();
        else if (acc) q.push_back(e);
        #1;
    endtask

    task automatic head_chk(input string nm, input logic [3:0] op, input logic [1:0] op1,
                            input bit op2, input bit w, input bit md, input bit ill);
        chk(nm, {out_valid, out_exec_op, out_op1_sel, out_op2_sel, out_is_word, out_is_muldiv, out_illegal},
                {1'b1, op, op1, op2, w, md, ill});
    endtask

    // Scoreboard monitor: handshake state vs queue occupancy, head vs queue front.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("in_ready", in_ready, (q.size() < TB_DEPTH));
            chk("out_valid", out_valid, (q.size() != 0));
            if (out_valid && q.size() != 0) begin
                chk("head", {out_exec_op, out_op1_sel, out_op2_sel, out_is_word, out_is_muldiv,
                             out_illegal, out_pc}, q[0]);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    initial begin
        // Power-on reset.
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_fields", {out_exec_op, out_op1_sel, out_op2_sel, out_is_word, out_is_muldiv,
                           out_illegal, out_pc}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_out_valid", out_valid, 0);
        mon_en = 1'b1;

        // ADD then SUB back-to-back.
        step(1, 32'h002081B3, 64'h1000, 1, 0);
        head_chk("add", 4'b0000, 2'd0, 0, 0, 0, 0);
        step(1, 32'h402081B3, 64'h1004, 1, 0);
        head_chk("sub", 4'b1000, 2'd0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);

        // Single-instruction directed decodes, each held then drained.
        step(1, 32'h4030D093, 64'h2000, 0, 0);
        head_chk("srai", 4'b1101, 2'd0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 32'h000010B7, 64'h2004, 0, 0);
        head_chk("lui", 4'b0000, 2'd2, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 32'h002080BB, 64'h2008, 0, 0);
        head_chk("addw", 4'b0000, 2'd0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 32'h022080B3, 64'h200C, 0, 0);
        head_chk("mul", 4'b0000, 2'd0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 32'h00000000, 64'h2010, 0, 0);
        head_chk("low_bits", 4'b0000, 2'd0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);

        // Fill to full: third push is refused, in_ready returns one cycle after the first pop.
        step(1, 32'h00208033, 64'h3000, 0, 0);
        step(1, 32'h00209033, 64'h3004, 0, 0);
        step(1, 32'h0020A033, 64'h3008, 0, 0);
        chk("full_in_ready", in_ready, 0);
        chk("full_head_pc", out_pc, 64'h3000);
        step(0, 0, 0, 1, 0);
        chk("pop_in_ready", in_ready, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);

        // Flush with two entries and a concurrent push.
        step(1, 32'h00208033, 64'h4000, 0, 0);
        step(1, 32'h00209033, 64'h4004, 0, 0);
        step(1, 32'h0020A033, 64'h4008, 0, 1);
        chk("flush_out_valid", out_valid, 0);
        step(1, 32'h0020B033, 64'h400C, 1, 0);
        chk("post_flush_pc", out_pc, 64'h400C);
        step(0, 0, 0, 1, 0);

        // Randomized traffic with sporadic flushes.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 9) < 7, rand_instr(), {$urandom, $urandom},
                 $urandom_range(0, 9) < 6, $urandom_range(0, 49) == 0);
        end

        // Reset mid-stream with two entries queued.
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 32'h002081B3, 64'h5000, 0, 0);
        step(1, 32'h402081B3, 64'h5004, 0, 0);
        mon_en = 1'b0;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_fields", {out_exec_op, out_op1_sel, out_op2_sel, out_is_word, out_is_muldiv,
                               out_illegal, out_pc}, 0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_in_ready", in_ready, 1);
        mon_en = 1'b1;
        step(1, 32'h4030D093, 64'h6000, 1, 0);
        step(0, 0, 0, 1, 0);

        // Bounded drain of anything left.
        for (int n = 0; n < 20 && q.size() != 0; n++) step(0, 0, 0, 1, 0);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries still expected, required 0", q.size());
        end
        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
